cpu_cu: RTL and testbench
=========================

Name: cpu_cu

Overview:
- Multi-cycle control unit for the 16-bit CPU execution unit (EU).
- Consumes the EU instruction register contents and C/N/Z flags. Produces every EU control strobe: we, sel, addr_sel, pc_sel, pc_ld, pc_inc, ir_ld.
- Also drives a req/rdy memory handshake.
- Pairs one-to-one with the EU: the EU executes, cpu_cu sequences.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- ir  input  16  EU instruction register; class = ir[11:9], cond = ir[15:12], offset = ir[7:0]
- C  input  1  EU carry flag
- N  input  1  EU negative flag
- Z  input  1  EU zero flag
- mem_rdy  input  1  memory completes the current read/write this cycle
- we  output  1  EU register-file write enable
- sel  output  1  EU write-source select; 1 = memory Din, 0 = ALU
- addr_sel  output  1  EU address mux; 1 = register, 0 = PC
- pc_sel  output  1  EU PC mux; 1 = Dout (jump), 0 = PC + sext(offset) (branch)
- pc_ld  output  1  load PC from the PC mux
- pc_inc  output  1  PC += 1
- ir_ld  output  1  load IR from Din
- mem_rd  output  1  memory read request
- mem_wr  output  1  memory write request; write data = EU Dout
- halted  output  1  HALT executed
- illegal  output  1  undefined class decoded
- retired  output  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

Behaviour:
- Reset (reset = 0, asynchronous): state goes to INIT, retired = 0, halted = 0, illegal = 0.
- All strobes are combinational from state and mem_rdy. All strobes are 0 in INIT, DECODE, HALT and ILL.
- INIT: no strobes; next state is FETCH.
- FETCH: mem_rd = 1, addr_sel = 0.
  - If mem_rdy: ir_ld = 1, pc_inc = 1, next state DECODE.
  - Otherwise hold FETCH with mem_rd held.
- DECODE: branch on ir[11:9]:
  - 000 goes to ALU
  - 001 goes to LOAD
  - 010 goes to STORE
  - 011 goes to BRANCH
  - 100 goes to JUMP
  - 111 goes to HALT
  - any other class goes to ILL
- ALU: we = 1, sel = 0 (Rw <- Rr op Rs, op = ir[15:12]). Next state FETCH; retire.
- LOAD: addr_sel = 1, mem_rd = 1.
  - If mem_rdy: we = 1, sel = 1, next state FETCH; retire.
  - Otherwise hold.
- STORE: addr_sel = 1, mem_wr = 1.
  - Store data is EU Dout; the program encodes a pass-S op in ir[15:12].
  - If mem_rdy: next state FETCH; retire. Otherwise hold.
- BRANCH: condition cond = ir[15:12] is evaluated on the current flags:
  - 0: always
  - 1: Z
  - 2: !Z
  - 3: C
  - 4: !C
  - 5: N
  - 6: !N
  - 7-15: never
  - If taken: pc_ld = 1, pc_sel = 0.
  - The target is relative to the already-incremented PC: target = PC_fetch + 1 + sext(ir[7:0]).
  - Next state FETCH; retire whether taken or not.
- JUMP: pc_ld = 1, pc_sel = 1 (PC <- Dout). Next state FETCH; retire.
- HALT: halted = 1, sticky. Stays in HALT until reset; not retired.
- ILL: illegal = 1, sticky. Stays in ILL until reset; not retired.
- Exclusivity rules:
  - mem_rd and mem_wr are never asserted together.
  - pc_ld and pc_inc are never asserted together.
  - we is never asserted outside ALU/LOAD.
- Handshake: mem_rd/mem_wr stay high until the cycle mem_rdy = 1. mem_rdy sampled while no request is active is ignored.
- Reset mid-transaction: requests drop immediately (asynchronous). The memory must tolerate an abandoned request.
- Minimum instruction latency with mem_rdy tied to 1:
  - ALU / BRANCH / JUMP: 3 cycles
  - LOAD / STORE: 3 cycles
  - Each wait cycle adds 1.
- retired increments by 1 on the final cycle of each completed instruction. 2^CNT_W - 1 wraps to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - state enumeration: INIT, FETCH, DECODE, ALU, LOAD, STORE, BRANCH, JUMP, HALT, ILL
  - class codes (CLS_ALU = 3'b000, and so on)
  - condition codes (CND_AL = 4'h0 through CND_NN = 4'h6)
- One sub-module: cpu_br_cond (cond[3:0], C, N, Z -> taken).

Test Plan:
- Reset low mid-FETCH with mem_rdy = 0 -> mem_rd = 0 immediately. After release: one INIT cycle, then mem_rd = 1; retired = 0.
- mem_rdy = 1, ir = 16'h0040 (ALU, Rw = 1) -> ir_ld & pc_inc in FETCH, we = 1 and sel = 0 two cycles later; retired = 1.
- LOAD ir = 16'h0208 with mem_rdy delayed 3 cycles -> addr_sel = 1 and mem_rd held 3 cycles. we = 1 and sel = 1 on the mem_rdy cycle only.
- BRANCH ir = 16'h16FE (cond Z, offset -2): with Z = 1, pc_ld = 1 and pc_sel = 0; with Z = 0, pc_ld = 0. retired increments in both cases.
- ir = 16'h0A00 (class 101) -> illegal = 1 and stays set. No further mem_rd; only reset clears it.
- ir = 16'h0E00 (HALT) -> halted = 1 and all strobes 0 for 100 cycles. retired wraps correctly when CNT_W = 4 after 16 ALU instructions.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: sequencer states,
// instruction class codes and branch condition codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    ALU    = 4'd3,
    LOAD   = 4'd4,
    STORE  = 4'd5,
    BRANCH = 4'd6,
    JUMP   = 4'd7,
    HALT   = 4'd8,
    ILL    = 4'd9
  } state_t;

  // Instruction class, ir[11:9]
  localparam logic [2:0] CLS_ALU    = 3'b000;
  localparam logic [2:0] CLS_LOAD   = 3'b001;
  localparam logic [2:0] CLS_STORE  = 3'b010;
  localparam logic [2:0] CLS_BRANCH = 3'b011;
  localparam logic [2:0] CLS_JUMP   = 3'b100;
  localparam logic [2:0] CLS_HALT   = 3'b111;

  // Branch condition, ir[15:12]; codes 7..15 are never taken
  localparam logic [3:0] CND_AL = 4'h0;
  localparam logic [3:0] CND_Z  = 4'h1;
  localparam logic [3:0] CND_NZ = 4'h2;
  localparam logic [3:0] CND_C  = 4'h3;
  localparam logic [3:0] CND_NC = 4'h4;
  localparam logic [3:0] CND_N  = 4'h5;
  localparam logic [3:0] CND_NN = 4'h6;

  function automatic logic [2:0] ir_class(input logic [15:0] ir);
    return ir[11:9];
  endfunction

  function automatic logic [3:0] ir_cond(input logic [15:0] ir);
    return ir[15:12];
  endfunction

endpackage

// File: rtl/cpu_br_cond.sv
// Branch condition evaluator: decides whether a conditional branch is taken
// from the condition code and the current EU flags.
module cpu_br_cond
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       C,
  input  logic       N,
  input  logic       Z,
  output logic       taken
);

  // Purely combinational flag test; unassigned codes never branch
  always_comb begin
    taken = 1'b0;
    case (cond)
      CND_AL:  taken = 1'b1;
      CND_Z:   taken = Z;
      CND_NZ:  taken = ~Z;
      CND_C:   taken = C;
      CND_NC:  taken = ~C;
      CND_N:   taken = N;
      CND_NN:  taken = ~N;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_cu.sv
// Multi-cycle control unit for the 16-bit CPU execution unit. Sequences
// fetch / decode / execute, drives every EU strobe and the memory req/rdy
// handshake, and counts retired instructions.
module cpu_cu
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      ir,
  input  logic             C,
  input  logic             N,
  input  logic             Z,
  input  logic             mem_rdy,
  output logic             we,
  output logic             sel,
  output logic             addr_sel,
  output logic             pc_sel,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ir_ld,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t state, next_state;
  logic   retire;
  logic   br_taken;

  // Opcode and offset bits are consumed by the EU datapath, not here
  logic unused_ir;
  assign unused_ir = ^ir[8:0];

  cpu_br_cond u_br_cond (
    .cond  (ir_cond(ir)),
    .C     (C),
    .N     (N),
    .Z     (Z),
    .taken (br_taken)
  );

  // State register; reset abandons any in-flight memory request at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= next_state;
  end

  // Next-state and strobe decode; strobes depend only on state and mem_rdy
  // (plus flags in BRANCH), so every unlisted strobe stays low
  always_comb begin
    next_state = state;
    we         = 1'b0;
    sel        = 1'b0;
    addr_sel   = 1'b0;
    pc_sel     = 1'b0;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    ir_ld      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    retire     = 1'b0;
    case (state)
      INIT: next_state = FETCH;
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_ld      = 1'b1;
          pc_inc     = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        case (ir_class(ir))
          CLS_ALU:    next_state = ALU;
          CLS_LOAD:   next_state = LOAD;
          CLS_STORE:  next_state = STORE;
          CLS_BRANCH: next_state = BRANCH;
          CLS_JUMP:   next_state = JUMP;
          CLS_HALT:   next_state = HALT;
          default:    next_state = ILL;
        endcase
      end
      ALU: begin
        we         = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      LOAD: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        if (mem_rdy) begin
          we         = 1'b1;
          sel        = 1'b1;
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      STORE: begin
        addr_sel = 1'b1;
        mem_wr   = 1'b1;
        if (mem_rdy) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        // PC was already bumped in FETCH, so the relative target is taken
        // from PC_fetch + 1
        pc_ld      = br_taken;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_ld      = 1'b1;
        pc_sel     = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    next_state = HALT;
      ILL:     next_state = ILL;
      default: next_state = INIT;
    endcase
  end

  // Sticky status: the terminal states are only left through reset
  assign halted  = (state == HALT);
  assign illegal = (state == ILL);

  // Retired-instruction counter, bumped on the last cycle of each instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_cpu_cu.sv
// Testbench for cpu_cu: instruction-level reference model pushes expected
// per-cycle strobe vectors into a scoreboard; a monitor on the falling
// edge pops and compares against the DUT.
module tb_cpu_cu;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [15:0]      ir = '0;
  logic             C = 1'b0, N = 1'b0, Z = 1'b0;
  logic             mem_rdy = 1'b0;
  logic             we, sel, addr_sel, pc_sel, pc_ld, pc_inc, ir_ld;
  logic             mem_rd, mem_wr, halted, illegal;
  logic [CNT_W-1:0] retired;

  cpu_cu #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ir(ir), .C(C), .N(N), .Z(Z),
    .mem_rdy(mem_rdy), .we(we), .sel(sel), .addr_sel(addr_sel),
    .pc_sel(pc_sel), .pc_ld(pc_ld), .pc_inc(pc_inc), .ir_ld(ir_ld),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Output bundle: we sel addr_sel pc_sel pc_ld pc_inc ir_ld mem_rd mem_wr halted illegal retired[3:0]
  typedef logic [14:0] vec_t;
  localparam vec_t B_WE  = 15'h4000;
  localparam vec_t B_SEL = 15'h2000;
  localparam vec_t B_AS  = 15'h1000;
  localparam vec_t B_PS  = 15'h0800;
  localparam vec_t B_PL  = 15'h0400;
  localparam vec_t B_PI  = 15'h0200;
  localparam vec_t B_IL  = 15'h0100;
  localparam vec_t B_RD  = 15'h0080;
  localparam vec_t B_WR  = 15'h0040;
  localparam vec_t B_H   = 15'h0020;
  localparam vec_t B_ILL = 15'h0010;

  vec_t act;
  assign act = {we, sel, addr_sel, pc_sel, pc_ld, pc_inc, ir_ld,
                mem_rd, mem_wr, halted, illegal, retired};

  vec_t             exp_q[$];
  string            tag_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  bit               mon_en = 1'b0;
  logic [CNT_W-1:0] ret_m = '0;

  task automatic check(input string nm, input vec_t a, input vec_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  // Monitor: one expected vector per cycle while the sequencer is live
  always @(negedge clk) begin : monitor
    vec_t  e;
    string t;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underflow @%0t: got %h expected none", $time, act);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, act, e);
      end
    end
  end

  function automatic logic [2:0] rnd3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Branch rule from the ISA: f = {C,N,Z}
  function automatic bit br_taken(input logic [3:0] cond, input logic [2:0] f);
    case (cond)
      4'd0:    return 1'b1;
      4'd1:    return f[0];
      4'd2:    return !f[0];
      4'd3:    return f[2];
      4'd4:    return !f[2];
      4'd5:    return f[1];
      4'd6:    return !f[1];
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus plus the strobes the ISA requires for it
  task automatic step(input logic [15:0] i, input logic rdy, input logic [2:0] f,
                      input vec_t strobes, input string nm);
    @(posedge clk);
    #1;
    ir      = i;
    mem_rdy = rdy;
    {C, N, Z} = f;
    exp_q.push_back(strobes | vec_t'(ret_m));
    tag_q.push_back(nm);
  endtask

  // Full instruction: fw fetch wait cycles, ew execute wait cycles, f = branch flags
  task automatic exec_instr(input logic [15:0] i, input int fw, input int ew,
                            input logic [2:0] f);
    for (int k = 0; k < fw; k++) step(i, 1'b0, rnd3(), B_RD, "fetch_wait");
    step(i, 1'b1, rnd3(), B_RD | B_IL | B_PI, "fetch");
    step(i, rbit(), rnd3(), '0, "decode");
    case (i[11:9])
      3'd0: begin
        step(i, rbit(), rnd3(), B_WE, "alu");
        ret_m++;
      end
      3'd1: begin
        for (int k = 0; k < ew; k++) step(i, 1'b0, rnd3(), B_AS | B_RD, "load_wait");
        step(i, 1'b1, rnd3(), B_AS | B_RD | B_WE | B_SEL, "load");
        ret_m++;
      end
      3'd2: begin
        for (int k = 0; k < ew; k++) step(i, 1'b0, rnd3(), B_AS | B_WR, "store_wait");
        step(i, 1'b1, rnd3(), B_AS | B_WR, "store");
        ret_m++;
      end
      3'd3: begin
        step(i, rbit(), f, br_taken(i[15:12], f) ? B_PL : '0, "branch");
        ret_m++;
      end
      3'd4: begin
        step(i, rbit(), rnd3(), B_PL | B_PS, "jump");
        ret_m++;
      end
      3'd7:    repeat (100) step(i, rbit(), rnd3(), B_H, "halt");
      default: repeat (30) step(i, rbit(), rnd3(), B_ILL, "illegal");
    endcase
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    ret_m = '0;
    exp_q.push_back('0);
    tag_q.push_back("init");
    mon_en = 1'b1;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear without a clock edge
  task automatic apply_reset(input string nm);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check(nm, act, '0);
    exp_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [2:0]  cls;
    logic [15:0] i;
    repeat (3) @(posedge clk);
    release_reset();
    step(16'h0000, 1'b0, 3'b000, B_RD, "fetch_wait");
    step(16'h0000, 1'b0, 3'b000, B_RD, "fetch_wait");
    apply_reset("reset_mid_fetch");

    exec_instr(16'h0040, 0, 0, 3'b000);
    exec_instr(16'h0208, 0, 3, 3'b000);
    exec_instr(16'h16FE, 0, 0, 3'b001);
    exec_instr(16'h16FE, 1, 0, 3'b000);
    exec_instr(16'h0800, 0, 0, 3'b000);
    exec_instr(16'h0400, 2, 2, 3'b000);

    repeat (16) exec_instr(16'h0040, $urandom_range(0, 2), 0, 3'b000);

    exec_instr(16'h0A00, 0, 0, 3'b000);
    apply_reset("reset_from_illegal");
    exec_instr(16'h0E00, 0, 0, 3'b000);
    apply_reset("reset_from_halt");

    repeat (300) begin
      if ($urandom_range(0, 99) < 3) cls = 3'($urandom_range(5, 7));
      else                           cls = 3'($urandom_range(0, 4));
      i = {4'($urandom_range(0, 15)), cls, 9'($urandom_range(0, 511))};
      exec_instr(i, $urandom_range(0, 3), $urandom_range(0, 3), rnd3());
      if (cls >= 3'd5) apply_reset("reset_after_stop");
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
